i2s_tx: RTL and testbench
=========================

// Module: i2s_tx
// PURPOSE
//  Stereo I2S transmitter: the serial output stage of the APU audio path, fed by the sample mixer.
//  Accepts left/right sample pairs over a valid/ready handshake into a one-deep holding register.
//  Derives bit_clk and frame_clk from clk and shifts data MSB-first, Philips I2S format.
//  Outputs drive the codec's BCLK/LRCLK/DIN pins directly.
// PARAMETERS
//  SAMPLE_W  16  sample width in bits, signed two's complement
//  SLOT_W    32  bit_clk periods per channel slot; must be >= SAMPLE_W+1
//  HALF_DIV  8   clk cycles per bit_clk half-period; must be >= 2
//                default 50 MHz/16 = 3.125 MHz bit_clk, 48.8 kHz frame
// PORTS
//  clk          in   1         system clock, single clock domain
//  reset        in   1         synchronous, active-high reset
//  in_left      in   SAMPLE_W  left sample
//  in_right     in   SAMPLE_W  right sample
//  in_valid     in   1         sample pair valid
//  in_ready     out  1         holding register empty; pair accepted when in_valid && in_ready
//  bit_clk      out  1         serial bit clock (BCLK)
//  frame_clk    out  1         word select (LRCLK): 0 = left slot, 1 = right slot
//  sdata        out  1         serial data; changes on bit_clk falling edge
//  frame_start  out  1         1-cycle pulse when a new frame loads
//  underrun     out  1         1-cycle pulse when a frame loads with the holding register empty
// BEHAVIOUR
//  Reset values:
//  - Outputs: bit_clk=0, frame_clk=0, sdata=0, frame_start=0, underrun=0, in_ready=1.
//  - Internal: div_cnt=0, bit_idx=2*SLOT_W-1, shift regs=0, last pair=0, holding empty.
//  Divider:
//  - div_cnt counts 0..HALF_DIV-1. At HALF_DIV-1 it wraps and bit_clk toggles.
//  - A 1->0 toggle is a "fall event".
//  - First rise appears after HALF_DIV clks; first fall after 2*HALF_DIV clks.
//  Bit index:
//  - On each fall event, bit_idx increments mod 2*SLOT_W.
//  - frame_clk = (new bit_idx >= SLOT_W). It is registered and updates on the same edge as bit_clk.
//  Frame load (fall event where bit_idx wraps to 0):
//  - If holding is full: copy holding into the left/right shift regs and the last-pair register,
//    then mark holding empty.
//  - If holding is empty: reload the last pair and pulse underrun. After reset the last pair is 0,
//    so zeros are sent.
//  - frame_start pulses on every load.
//  Slot data, for position p = bit_idx mod SLOT_W:
//  - p=0: sdata=0 (I2S one-BCLK delay).
//  - p=1..SAMPLE_W: sample bit SAMPLE_W-p, MSB first.
//  - p>SAMPLE_W: sdata=0.
//  - sdata updates only on fall events.
//  Handshake:
//  - in_ready = holding empty, registered. It falls the cycle after an accept and rises the cycle
//    after a load empties holding.
//  - Accept and load in the same cycle: the load uses the old holding contents; the accepted pair
//    goes into holding, and holding stays full.
//  - in_valid while not ready: ignored. The source must hold its data.
//  Reset mid-frame: everything returns to reset values on the next clk edge. The partial frame is
//  dropped and the held pair is discarded.
//  Timing: frame period = 4*SLOT_W*HALF_DIV clks (1024 at defaults). One pair is consumed per frame.
// STRUCTURE
//  Package apu_audio_pkg:
//  - SAMPLE_W default constant and the sample_t typedef.
//  - I2S_SLOT_W constant, shared with the mixer and the codec config.
//  Sub-module i2s_bclk_gen (params HALF_DIV, SLOT_W):
//  - Contains div_cnt and bit_idx.
//  - Outputs bit_clk, frame_clk, fall_evt, frame_load and slot position.
//  The top level holds the holding register, shift regs and handshake.
// TESTING
//  1 Reset, then in_valid=1 with L=16'hA5F0, R=16'h0FF1, HALF_DIV=2:
//    - in_ready drops 1 clk after the accept.
//    - First frame_start comes at clk 4.
//    - Left slot serializes 0,1010010111110000,0*15; right slot serializes 0,0000111111110001,0*15.
//  2 No input after reset: frame_start and underrun pulse every 256 clks (HALF_DIV=2);
//    sdata stays 0 and frame_clk toggles every 128 clks.
//  3 Feed one pair (8000, 7FFF), then stop:
//    - Frame 1 carries the pair.
//    - Frame 2 underruns and repeats 8000/7FFF bit-exact.
//  4 Back-pressure: hold in_valid=1 with an incrementing pair:
//    - Exactly one accept per frame.
//    - An accept on the frame_load cycle is sent in the next frame. No pair is lost or duplicated.
//  5 Assert reset mid-right-slot for 1 clk: all outputs return to reset values next clk,
//    in_ready=1, and the next frame sends zeros with underrun.
//  6 Checker: sdata and frame_clk change only on the clk where bit_clk falls; bit_clk duty is
//    exactly 50%.

Source files
------------

// File: rtl/apu_audio_pkg.sv
// apu_audio_pkg: shared audio-path widths and sample type for the mixer, I2S output and codec config
package apu_audio_pkg;
  localparam int AUDIO_SAMPLE_W = 16;
  localparam int I2S_SLOT_W = 32;
  typedef logic signed [AUDIO_SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: divides clk into bit_clk/frame_clk and tracks the bit index within the stereo frame
module i2s_bclk_gen #(
  parameter int HALF_DIV = 8,
  parameter int SLOT_W = 32,
  localparam int IW = $clog2(2*SLOT_W)
)(
  input  logic          clk,
  input  logic          reset,
  output logic          bit_clk,
  output logic          frame_clk,
  output logic          fall_evt,
  output logic          frame_load,
  output logic [IW-1:0] slot_pos,
  output logic          slot_right
);
  localparam int DW = $clog2(HALF_DIV);
  logic [DW-1:0] div_cnt;
  logic [IW-1:0] bit_idx, idx_nxt;
  logic wrap;
  assign wrap = div_cnt == DW'(HALF_DIV-1);
  assign fall_evt = wrap && bit_clk;
  assign idx_nxt = bit_idx == IW'(2*SLOT_W-1) ? '0 : bit_idx + IW'(1);
  assign slot_right = idx_nxt >= IW'(SLOT_W);
  // position and slot refer to the bit about to be presented on this fall
  assign slot_pos = slot_right ? idx_nxt - IW'(SLOT_W) : idx_nxt;
  assign frame_load = fall_evt && idx_nxt == '0;
  always_ff @(posedge clk)
    if (reset) begin
      div_cnt <= '0;
      bit_clk <= 1'b0;
      bit_idx <= IW'(2*SLOT_W-1);
      frame_clk <= 1'b0;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + DW'(1);
      if (wrap) bit_clk <= ~bit_clk;
      if (fall_evt) begin
        bit_idx <= idx_nxt;
        frame_clk <= slot_right;
      end
    end
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: stereo Philips I2S transmitter with a one-deep holding register and underrun repeat
module i2s_tx import apu_audio_pkg::*; #(
  parameter int SAMPLE_W = AUDIO_SAMPLE_W,
  parameter int SLOT_W = I2S_SLOT_W,
  parameter int HALF_DIV = 8
)(
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] in_left,
  input  logic [SAMPLE_W-1:0] in_right,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                bit_clk,
  output logic                frame_clk,
  output logic                sdata,
  output logic                frame_start,
  output logic                underrun
);
  localparam int IW = $clog2(2*SLOT_W);
  logic fall_evt, frame_load, slot_right, accept, shift, data_bit;
  logic [IW-1:0] slot_pos;
  logic [SAMPLE_W-1:0] hold_l, hold_r, last_l, last_r, left_sr, right_sr, load_l, load_r;
  i2s_bclk_gen #(.HALF_DIV(HALF_DIV), .SLOT_W(SLOT_W)) u_bclk (
    .clk(clk), .reset(reset), .bit_clk(bit_clk), .frame_clk(frame_clk), .fall_evt(fall_evt),
    .frame_load(frame_load), .slot_pos(slot_pos), .slot_right(slot_right)
  );
  assign accept = in_valid && in_ready;
  // in_ready doubles as the holding-empty flag, so an empty load replays the last pair
  assign load_l = in_ready ? last_l : hold_l;
  assign load_r = in_ready ? last_r : hold_r;
  assign shift = slot_pos != '0 && slot_pos <= IW'(SAMPLE_W);
  assign data_bit = shift && (slot_right ? right_sr[SAMPLE_W-1] : left_sr[SAMPLE_W-1]);
  always_ff @(posedge clk)
    if (reset) begin
      in_ready <= 1'b1;
      hold_l <= '0;
      hold_r <= '0;
      last_l <= '0;
      last_r <= '0;
      left_sr <= '0;
      right_sr <= '0;
      sdata <= 1'b0;
      frame_start <= 1'b0;
      underrun <= 1'b0;
    end else begin
      frame_start <= frame_load;
      underrun <= frame_load && in_ready;
      in_ready <= !accept && (in_ready || frame_load);
      if (accept) begin
        hold_l <= in_left;
        hold_r <= in_right;
      end
      if (frame_load) begin
        left_sr <= load_l;
        right_sr <= load_r;
        last_l <= load_l;
        last_r <= load_r;
      end else if (fall_evt && shift && !slot_right) left_sr <= {left_sr[SAMPLE_W-2:0], 1'b0};
      else if (fall_evt && shift) right_sr <= {right_sr[SAMPLE_W-2:0], 1'b0};
      if (fall_evt) sdata <= data_bit;
    end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed checks of framing, serial bit order, underrun replay, back-pressure and reset
module tb_i2s_tx;
  localparam int HALF = 2;
  localparam int FALL = 2*HALF;
  localparam int SW = 16;
  localparam int SL = 32;
  logic clk, reset, in_valid, in_ready, bit_clk, frame_clk, sdata, frame_start, underrun;
  logic [SW-1:0] in_left, in_right;
  int n_checks = 0, n_err = 0, n_acc = 0;
  logic feed_on = 1'b0;
  i2s_tx #(.SAMPLE_W(SW), .SLOT_W(SL), .HALF_DIV(HALF)) dut (
    .clk(clk), .reset(reset), .in_left(in_left), .in_right(in_right), .in_valid(in_valid),
    .in_ready(in_ready), .bit_clk(bit_clk), .frame_clk(frame_clk), .sdata(sdata),
    .frame_start(frame_start), .underrun(underrun)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (cycles) step();
    reset = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check(tag, {bit_clk, frame_clk, sdata, frame_start, underrun, in_ready}, 6'b000001);
  endtask

  task automatic wait_frame(output logic ur);
    int t = 0;
    while (frame_start !== 1'b1 && t < 2000) begin
      step();
      t++;
    end
    check("frame_wait", frame_start, 1'b1);
    ur = underrun;
  endtask

  task automatic grab(output logic [63:0] b);
    b[63] = sdata;
    for (int k = 1; k < 64; k++) begin
      repeat (FALL) step();
      b[63-k] = sdata;
      if (k == 31) check("fclk_left", frame_clk, 1'b0);
      if (k == 32) check("fclk_right", frame_clk, 1'b1);
    end
  endtask

  task automatic frame_chk(input string tag, input logic [SW-1:0] l, input logic [SW-1:0] r, input logic exp_ur);
    logic ur;
    logic [63:0] b;
    wait_frame(ur);
    check({tag, "_ur"}, ur, exp_ur);
    grab(b);
    check({tag, "_left"}, b[63:32], {1'b0, l, {(SL-SW-1){1'b0}}});
    check({tag, "_right"}, b[31:0], {1'b0, r, {(SL-SW-1){1'b0}}});
  endtask

  task automatic send(input logic [SW-1:0] l, input logic [SW-1:0] r);
    logic acc;
    int t = 0;
    in_left = l;
    in_right = r;
    in_valid = 1'b1;
    do begin
      acc = in_ready;
      step();
      t++;
    end while (!acc && t < 3000);
    check("send_accept", acc, 1'b1);
    in_valid = 1'b0;
  endtask

  always @(posedge clk)
    if (feed_on && in_valid && in_ready) begin
      #1;
      n_acc++;
      in_left = 16'h1000 + 16'(n_acc);
      in_right = 16'h2000 + 16'(n_acc);
    end

  logic r_q, p_bclk, p_fclk, p_sd;
  bit armed = 1'b0;
  int run = 0;
  always @(posedge clk) r_q <= reset;
  always @(negedge clk) begin
    if (r_q) begin
      armed = 1'b1;
      run = 0;
    end else if (armed) begin
      run++;
      if (sdata !== p_sd || frame_clk !== p_fclk) check("edge_sync", {p_bclk, bit_clk}, 2'b10);
      if (bit_clk !== p_bclk) begin
        check("half_period", run, HALF);
        run = 0;
      end
    end
    p_bclk = bit_clk;
    p_fclk = frame_clk;
    p_sd = sdata;
  end

  initial begin
    in_left = '0;
    in_right = '0;
    in_valid = 1'b0;
    do_reset(2);
    check_idle("reset_vals");
    for (int n = 1; n <= 520; n++) begin
      step();
      check("idle_fs", frame_start, n >= 4 && (n - 4) % 256 == 0);
      check("idle_ur", underrun, n >= 4 && (n - 4) % 256 == 0);
      check("idle_fclk", frame_clk, n >= 4 && (n - 4) % 256 >= 128);
      check("idle_sdata", sdata, 1'b0);
    end
    do_reset(1);
    in_left = 16'hA5F0;
    in_right = 16'h0FF1;
    in_valid = 1'b1;
    step();
    check("t1_ready_drop", in_ready, 1'b0);
    check("t1_fs_e1", frame_start, 1'b0);
    in_valid = 1'b0;
    step();
    check("t1_bclk_rise", bit_clk, 1'b1);
    step();
    check("t1_fs_e3", frame_start, 1'b0);
    step();
    check("t1_fs_e4", frame_start, 1'b1);
    check("t1_ur", underrun, 1'b0);
    check("t1_ready_rise", in_ready, 1'b1);
    begin
      logic [63:0] b;
      grab(b);
      check("t1_left", b[63:32], {1'b0, 16'hA5F0, 15'b0});
      check("t1_right", b[31:0], {1'b0, 16'h0FF1, 15'b0});
    end
    send(16'h8000, 16'h7FFF);
    frame_chk("t3_f1", 16'h8000, 16'h7FFF, 1'b0);
    frame_chk("t3_f2", 16'h8000, 16'h7FFF, 1'b1);
    repeat (FALL - 1) step();
    n_acc = 0;
    in_left = 16'h1000;
    in_right = 16'h2000;
    in_valid = 1'b1;
    feed_on = 1'b1;
    frame_chk("t4_coincide", 16'h8000, 16'h7FFF, 1'b1);
    frame_chk("t4_p0", 16'h1000, 16'h2000, 1'b0);
    frame_chk("t4_p1", 16'h1001, 16'h2001, 1'b0);
    frame_chk("t4_p2", 16'h1002, 16'h2002, 1'b0);
    check("t4_accepts", n_acc, 4);
    feed_on = 1'b0;
    in_valid = 1'b0;
    begin
      logic ur;
      wait_frame(ur);
      check("t5_pre_ur", ur, 1'b0);
    end
    repeat (40*FALL) step();
    check("t5_mid_right", frame_clk, 1'b1);
    do_reset(1);
    check_idle("t5_reset_vals");
    frame_chk("t5_zero", 16'h0000, 16'h0000, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
